spi_mem_master: RTL and testbench

SPI_MEM_MASTER -- requirements
Module: spi_mem_master

---
 rtl/spi_mem_pkg.sv | 29 ++
 rtl/spi_mem_watchdog.sv | 40 ++++
 rtl/spi_mem_master.sv | 199 +++++++++++++++++++
 tb/tb_spi_mem_master.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory master: FSM states, opcode
// encodings, frame lengths and the default wait timeout.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SHIFT,
    WAIT_READY,
    RECV,
    WAIT_DONE
  } state_e;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  localparam int FRAME_LEN_RD    = 8;
  localparam int FRAME_LEN_WR    = 16;
  localparam int TIMEOUT_DEFAULT = 40;

  // Number of serial bits following the opcode for a given operation.
  function automatic logic [4:0] frame_len(input logic is_wr);
    if (is_wr == OP_WRITE) begin
      return 5'(FRAME_LEN_WR);
    end
    return 5'(FRAME_LEN_RD);
  endfunction

endpackage

// File: rtl/spi_mem_watchdog.sv
// Wait-state counter: held at zero while cleared, counts while enabled and
// flags expiry on the TIMEOUT-th enabled cycle.
module spi_mem_watchdog
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign expired = enable && (count_q == LIMIT);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/spi_mem_master.sv
// SPI master for a simple serial memory slave: sends opcode + LSB-first
// address (and data for writes), then waits for the slave handshake pulses.
module spi_mem_master
  import spi_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       req,
  input  logic       wr,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] dout,
  output logic       cs,
  output logic       mosi,
  input  logic       miso,
  input  logic       ready,
  input  logic       op_done
);

  state_e      state_q, state_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] shift_q, shift_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  rx_q, rx_d;
  logic [7:0]  dout_q, dout_d;
  logic        cs_q, cs_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic wd_clear;
  logic wd_enable;
  logic wd_expired;

  // The watchdog only runs in the two handshake waits and is zeroed otherwise,
  // so each wait starts from a fresh count.
  assign wd_enable = (state_q == WAIT_READY) || (state_q == WAIT_DONE);
  assign wd_clear  = !wd_enable;

  spi_mem_watchdog #(
    .TIMEOUT(TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rstn   (rstn),
    .clear  (wd_clear),
    .enable (wd_enable),
    .expired(wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    is_wr_d   = is_wr_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    dout_d    = dout_q;
    cs_d      = cs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      IDLE: begin
        cs_d   = 1'b1;
        mosi_d = 1'b0;
        if (req) begin
          is_wr_d   = wr;
          shift_d   = {din, addr};
          bit_cnt_d = 5'd0;
          cs_d      = 1'b0;
          mosi_d    = wr;
          busy_d    = 1'b1;
          state_d   = START;
        end
      end

      // Opcode stays on mosi for two cycles so the slave can sample it.
      START: begin
        if (bit_cnt_q == 5'd0) begin
          bit_cnt_d = 5'd1;
        end else begin
          mosi_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[15:1]};
          bit_cnt_d = 5'd1;
          state_d   = SHIFT;
        end
      end

      SHIFT: begin
        if (bit_cnt_q == frame_len(is_wr_q)) begin
          cs_d      = 1'b1;
          mosi_d    = 1'b0;
          bit_cnt_d = 5'd0;
          if (is_wr_q == OP_WRITE) begin
            state_d = WAIT_DONE;
          end else begin
            state_d = WAIT_READY;
          end
        end else begin
          mosi_d    = shift_q[0];
          shift_d   = {1'b0, shift_q[15:1]};
          bit_cnt_d = bit_cnt_q + 5'd1;
        end
      end

      WAIT_READY: begin
        if (ready) begin
          bit_cnt_d = 5'd0;
          state_d   = RECV;
        end else if (wd_expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end

      // Shifting in from the top leaves the first received bit in rx_q[0].
      RECV: begin
        rx_d      = {miso, rx_q[7:1]};
        bit_cnt_d = bit_cnt_q + 5'd1;
        if (bit_cnt_q == 5'd7) begin
          bit_cnt_d = 5'd0;
          state_d   = WAIT_DONE;
        end
      end

      WAIT_DONE: begin
        if (op_done) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (is_wr_q == OP_READ) begin
            dout_d = rx_q;
          end
        end else if (wd_expired) begin
          done_d  = 1'b1;
          err_d   = 1'b1;
          busy_d  = 1'b0;
          cs_d    = 1'b1;
          mosi_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        cs_d    = 1'b1;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      is_wr_q   <= 1'b0;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      dout_q    <= '0;
      cs_q      <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      is_wr_q   <= is_wr_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      dout_q    <= dout_d;
      cs_q      <= cs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign err  = err_q;
  assign dout = dout_q;
  assign cs   = cs_q;
  assign mosi = mosi_q;

endmodule

// File: tb/tb_spi_mem_master.sv
// Directed bench for spi_mem_master with a behavioural memory slave that
// answers frames with the nominal ready/op_done timing.
module tb_spi_mem_master;

  logic       clk;
  logic       rstn;
  logic       req;
  logic       wr;
  logic [7:0] addr;
  logic [7:0] din;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] dout;
  logic       cs;
  logic       mosi;
  logic       miso;
  logic       ready;
  logic       op_done;

  logic slv_ready;
  logic slv_op_done;
  logic slv_miso;
  logic stray;
  logic slave_en;

  assign ready   = slv_ready | stray;
  assign op_done = slv_op_done | stray;
  assign miso    = slv_miso;

  int errors;
  int checks;
  int done_cycle;
  logic err_seen;
  logic cs_seen;
  logic busy_seen;
  logic [7:0] dout_seen;
  logic [127:0] cs_trace;
  logic [127:0] mosi_trace;
  logic [127:0] busy_trace;
  logic [15:0] last_frame;
  logic [15:0] seq;
  logic saw_done;

  spi_mem_master #(
    .TIMEOUT(40)
  ) dut (
    .clk    (clk),
    .rstn   (rstn),
    .req    (req),
    .wr     (wr),
    .addr   (addr),
    .din    (din),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .dout   (dout),
    .cs     (cs),
    .mosi   (mosi),
    .miso   (miso),
    .ready  (ready),
    .op_done(op_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory slave: samples on falling edges, stores writes and replays reads.
  initial begin : slave
    logic [7:0] mem [256];
    logic [15:0] frame;
    logic op;
    logic [7:0] rd;
    int nbits;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    slv_ready   = 1'b0;
    slv_op_done = 1'b0;
    slv_miso    = 1'b0;
    last_frame  = '0;
    forever begin
      @(negedge clk);
      if (rstn && !cs && slave_en) begin
        op = mosi;
        @(negedge clk);
        @(negedge clk);
        nbits = 0;
        frame = '0;
        while (!cs && nbits < 16) begin
          frame[nbits] = mosi;
          nbits++;
          @(negedge clk);
        end
        if (cs && op && nbits == 16) begin
          last_frame = frame;
          mem[frame[7:0]] = frame[15:8];
          @(negedge clk);
          slv_op_done = 1'b1;
          @(negedge clk);
          slv_op_done = 1'b0;
        end else if (cs && !op && nbits == 8) begin
          last_frame = frame;
          rd = mem[frame[7:0]];
          @(negedge clk);
          slv_ready = 1'b1;
          @(negedge clk);
          slv_ready = 1'b0;
          for (int k = 0; k < 8; k++) begin
            slv_miso = rd[k];
            @(negedge clk);
          end
          slv_miso = 1'b0;
          @(negedge clk);
          slv_op_done = 1'b1;
          @(negedge clk);
          slv_op_done = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Issues one request from a falling edge; cycle n of the traces is the value
  // seen just after edge Tn, with T0 the accept edge.
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                               input int limit, input int stray_at, input logic hold);
    int cyc;
    logic got;
    req  = 1'b1;
    wr   = w;
    addr = a;
    din  = d;
    @(posedge clk);
    cyc        = 0;
    got        = 1'b0;
    done_cycle = -1;
    err_seen   = 1'b0;
    cs_seen    = 1'b0;
    busy_seen  = 1'b1;
    dout_seen  = 8'h00;
    cs_trace   = '0;
    mosi_trace = '0;
    busy_trace = '0;
    while (!got && cyc < limit) begin
      @(negedge clk);
      if (!hold) req = 1'b0;
      stray = (stray_at >= 0) && (cyc >= stray_at) && (cyc < stray_at + 6);
      cs_trace[cyc]   = cs;
      mosi_trace[cyc] = mosi;
      busy_trace[cyc] = busy;
      if (done) begin
        got        = 1'b1;
        done_cycle = cyc;
        err_seen   = err;
        cs_seen    = cs;
        busy_seen  = busy;
        dout_seen  = dout;
      end
      cyc++;
    end
    stray = 1'b0;
  endtask

  initial begin
    errors   = 0;
    checks   = 0;
    rstn     = 1'b0;
    req      = 1'b0;
    wr       = 1'b0;
    addr     = 8'h00;
    din      = 8'h00;
    stray    = 1'b0;
    slave_en = 1'b1;
    repeat (3) @(negedge clk);

    checkOutput("reset_cs", 32'(cs), 32'h1);
    checkOutput("reset_mosi", 32'(mosi), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_done", 32'(done), 32'h0);
    checkOutput("reset_err", 32'(err), 32'h0);
    checkOutput("reset_dout", 32'(dout), 32'h0);
    rstn = 1'b1;
    @(negedge clk);

    $display("[TB] write 0x05 <- 0xA5");
    applyStimulus(1'b1, 8'h05, 8'hA5, 60, -1, 1'b0);
    for (int k = 0; k < 16; k++) seq[k] = mosi_trace[2 + k];
    checkOutput("wr_busy_t0", 32'(busy_trace[0]), 32'h1);
    checkOutput("wr_cs_t0", 32'(cs_trace[0]), 32'h0);
    checkOutput("wr_opcode_t0", 32'(mosi_trace[0]), 32'h1);
    checkOutput("wr_opcode_t1", 32'(mosi_trace[1]), 32'h1);
    checkOutput("wr_mosi_bits", 32'(seq), 32'hA505);
    checkOutput("wr_cs_t17", 32'(cs_trace[17]), 32'h0);
    checkOutput("wr_cs_t18", 32'(cs_trace[18]), 32'h1);
    checkOutput("wr_mosi_t18", 32'(mosi_trace[18]), 32'h0);
    checkOutput("wr_done_cycle", 32'(done_cycle), 32'd20);
    checkOutput("wr_err", 32'(err_seen), 32'h0);
    checkOutput("wr_busy_at_done", 32'(busy_seen), 32'h0);
    checkOutput("wr_slave_frame", 32'(last_frame), 32'hA505);

    $display("[TB] read 0x05");
    applyStimulus(1'b0, 8'h05, 8'h00, 60, -1, 1'b0);
    checkOutput("rd_cs_t9", 32'(cs_trace[9]), 32'h0);
    checkOutput("rd_cs_t10", 32'(cs_trace[10]), 32'h1);
    checkOutput("rd_done_cycle", 32'(done_cycle), 32'd22);
    checkOutput("rd_dout", 32'(dout_seen), 32'hA5);
    checkOutput("rd_err", 32'(err_seen), 32'h0);
    repeat (3) @(negedge clk);
    checkOutput("rd_dout_held", 32'(dout), 32'hA5);
    checkOutput("rd_done_pulse", 32'(done), 32'h0);

    $display("[TB] back-to-back write 0x1F <- 0x3C then read");
    applyStimulus(1'b1, 8'h1F, 8'h3C, 60, -1, 1'b0);
    checkOutput("b2b_wr_done", 32'(done_cycle), 32'd20);
    checkOutput("b2b_cs_between", 32'(cs_seen), 32'h1);
    applyStimulus(1'b0, 8'h1F, 8'h00, 60, -1, 1'b0);
    checkOutput("b2b_rd_cs_t0", 32'(cs_trace[0]), 32'h0);
    checkOutput("b2b_rd_done", 32'(done_cycle), 32'd22);
    checkOutput("b2b_rd_dout", 32'(dout_seen), 32'h3C);

    $display("[TB] read 0x02 with slave disconnected");
    slave_en = 1'b0;
    applyStimulus(1'b0, 8'h02, 8'h00, 80, -1, 1'b0);
    checkOutput("to_done_cycle", 32'(done_cycle), 32'd50);
    checkOutput("to_err", 32'(err_seen), 32'h1);
    checkOutput("to_cs", 32'(cs_seen), 32'h1);
    checkOutput("to_busy", 32'(busy_seen), 32'h0);
    checkOutput("to_dout_kept", 32'(dout_seen), 32'h3C);
    @(negedge clk);
    checkOutput("to_err_pulse", 32'(err), 32'h0);
    slave_en = 1'b1;

    $display("[TB] stray handshake pulses");
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    checkOutput("stray_idle_done", 32'(done), 32'h0);
    checkOutput("stray_idle_busy", 32'(busy), 32'h0);
    applyStimulus(1'b1, 8'h66, 8'h99, 60, 0, 1'b0);
    checkOutput("stray_wr_done", 32'(done_cycle), 32'd20);
    checkOutput("stray_wr_frame", 32'(last_frame), 32'h9966);
    applyStimulus(1'b0, 8'h66, 8'h00, 60, -1, 1'b0);
    checkOutput("stray_rd_dout", 32'(dout_seen), 32'h99);

    $display("[TB] reset during a write");
    req  = 1'b1;
    wr   = 1'b1;
    addr = 8'h40;
    din  = 8'h77;
    @(posedge clk);
    @(negedge clk);
    req = 1'b0;
    repeat (8) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    checkOutput("rst_mid_cs", 32'(cs), 32'h1);
    checkOutput("rst_mid_busy", 32'(busy), 32'h0);
    checkOutput("rst_mid_dout", 32'(dout), 32'h0);
    @(negedge clk);
    rstn     = 1'b1;
    saw_done = 1'b0;
    repeat (25) begin
      @(negedge clk);
      saw_done = saw_done | done;
    end
    checkOutput("rst_mid_no_done", 32'(saw_done), 32'h0);
    applyStimulus(1'b1, 8'h40, 8'h77, 60, -1, 1'b0);
    checkOutput("rst_after_wr_done", 32'(done_cycle), 32'd20);
    checkOutput("rst_after_wr_err", 32'(err_seen), 32'h0);
    applyStimulus(1'b0, 8'h40, 8'h00, 60, -1, 1'b0);
    checkOutput("rst_after_rd_dout", 32'(dout_seen), 32'h77);

    $display("[TB] req held high across two writes");
    applyStimulus(1'b1, 8'hC8, 8'h5A, 60, -1, 1'b1);
    checkOutput("hold_first_done", 32'(done_cycle), 32'd20);
    checkOutput("hold_gap_busy", 32'(busy), 32'h0);
    applyStimulus(1'b1, 8'hC8, 8'h5A, 60, -1, 1'b1);
    req = 1'b0;
    checkOutput("hold_second_busy_t0", 32'(busy_trace[0]), 32'h1);
    checkOutput("hold_second_done", 32'(done_cycle), 32'd20);
    @(negedge clk);
    checkOutput("hold_released_busy", 32'(busy), 32'h0);
    applyStimulus(1'b0, 8'hC8, 8'h00, 60, -1, 1'b0);
    checkOutput("hold_rd_dout", 32'(dout_seen), 32'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
